hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Tracks the destination register, remaining latency (Tnew) and result kind of every in-flight instruction in the E, M and W stages using internal shadow records.
- Each cycle it drives the select codes of the D-, E- and M-stage forwarding muxes and raises a stall when a D-stage operand is not yet producible.
- It also runs the multiply/divide busy counter and stalls HI/LO consumers while the unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded on a mult/multu issue.
- DIV_CYCLES, 10, busy cycles loaded on a div/divu issue.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- d_rs  in  5  rs field of the D-stage instruction.
- d_rt  in  5  rt field of the D-stage instruction.
- d_rs_tuse  in  2  stage in which rs is needed: 0=D, 1=E, 2=M, 3=unused.
- d_rt_tuse  in  2  same encoding, for rt.
- d_dst  in  5  destination GPR of the D-stage instruction; 0 means no write.
- d_tnew  in  2  cycles after E entry until the result exists: 0=link, 1=ALU, 2=load.
- d_link  in  1  result is the link value (PC+8).
- d_md_start  in  2  00=none, 01=mult, 10=div, 11=reserved (treated as none).
- d_md_use  in  1  instruction reads or writes HI/LO.
- stall  out  1  hold PC and the D register; insert a bubble into E.
- fwd_rs_d  out  3  D-stage rs mux select.
- fwd_rt_d  out  3  D-stage rt mux select.
- fwd_rs_e  out  3  E-stage rs mux select.
- fwd_rt_e  out  3  E-stage rt mux select.
- fwd_rt_m  out  3  M-stage store-data mux select.

Select encodings come from the shared header:
- mf_rd = 0 (register file / pipeline value)
- mf_pc4e = 1
- mf_ao = 2
- mf_pc4m = 3
- mf_wd = 4

Behaviour:

Stage records:
- Each of E, M, W holds {dst[4:0], tnew[1:0], link}. E and M also hold rs and rt.
- On every rising edge with reset=0:
  - W <= M.
  - M <= E with tnew = (E.tnew==0) ? 0 : E.tnew-1.
  - E <= D fields when stall=0; when stall=1, E <= bubble (dst=0, tnew=0, link=0, rs=rt=0).
  - On W entry, tnew is forced to 0.
- reset=1: all records become bubbles and the md counter clears to 0. Combinational outputs then read stall=0 and all fwd_* = mf_rd. Reset mid-operation discards in-flight state with no residue.

Matching:
- Stage X matches operand r iff X.dst == r and r != 0.
- Register $0 never matches and never stalls.
- Priority is youngest first: E > M > W.

D-stage select (fwd_rs_d, fwd_rt_d), from the first matching stage:
- E match with tnew=0 and link=1 -> mf_pc4e.
- M match with tnew=0 -> mf_pc4m if link=1, else mf_ao.
- W match -> mf_wd.
- Otherwise mf_rd. A matching stage with tnew>0 also yields mf_rd; the stall covers that case.

E-stage select (fwd_rs_e, fwd_rt_e), using E.rs/E.rt:
- M match with tnew=0 -> mf_pc4m if link=1, else mf_ao.
- W match -> mf_wd.
- Otherwise mf_rd.

M-stage select (fwd_rt_m), using M.rt: W match -> mf_wd, else mf_rd.

Stall:
- Operand stall when tuse != 3 and the youngest matching stage has tnew > tuse.
- Mult/div stall when busy (counter != 0) and (d_md_use=1 or d_md_start != 0).
- stall = rs_stall | rt_stall | md_stall.
- stall is combinational in the same cycle, from registered state and D inputs.

Multiply/divide counter:
- When d_md_start = 01 or 10 and stall=0, the counter loads MULT_CYCLES or DIV_CYCLES respectively.
- Otherwise it decrements while nonzero.
- A load takes precedence over a decrement.

Boundaries:
- A load in E with tnew=2 and tuse=1 gives exactly one stall cycle; the next cycle the record is in M with tnew=1, then forwards from W as mf_wd.
- When rs == rt, both selects are identical and the stall is not double counted.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds ports stall_cnt out 32 and md_stall_cnt out 32.
  - stall_cnt increments on every cycle with stall=1.
  - md_stall_cnt increments on every cycle with md_stall=1.
  - Both clear on reset and wrap at 2^32.
- Not defined: neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- addu $3 in D, then beq $3,$3 (tuse 0):
  - beq in D stalls 1 cycle; the next cycle fwd_rs_d = fwd_rt_d = mf_ao.
- lw $5 followed by addu $6,$5,$1 (tuse 1):
  - stall=1 for exactly 1 cycle.
  - Next cycle fwd_rs_e = mf_rd (record in M, tnew=1).
  - The cycle after, addu is in E and the load is in W: fwd_rs_e = mf_wd.
- jal (dst 31, link) followed immediately by jr $31 (tuse 0):
  - No stall; fwd_rs_d = mf_pc4e.
- addu $0,... followed by beq $0,$0:
  - stall=0 and all fwd_* = mf_rd.
- mult issued, then mflo on the next cycle:
  - With MULT_CYCLES=5, stall=1 for 5 cycles, then the instruction issues.
  - div followed by mult stalls 10 cycles.
- Assert reset while a load-use stall and an md count are active:
  - The next cycle stall=0, all fwd_* = mf_rd, and the counter is 0.
  - With HAZARD_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, plus mult/div busy tracking.
// Define HAZARD_STATS_EN to add the stall_cnt / md_stall_cnt performance counters.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic [4:0]  d_dst,
  input  logic [1:0]  d_tnew,
  input  logic        d_link,
  input  logic [1:0]  d_md_start,
  input  logic        d_md_use,
  output logic        stall,
  output logic [2:0]  fwd_rs_d,
  output logic [2:0]  fwd_rt_d,
  output logic [2:0]  fwd_rs_e,
  output logic [2:0]  fwd_rt_e,
  output logic [2:0]  fwd_rt_m
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  localparam logic [2:0] mf_rd   = 3'd0;
  localparam logic [2:0] mf_pc4e = 3'd1;
  localparam logic [2:0] mf_ao   = 3'd2;
  localparam logic [2:0] mf_pc4m = 3'd3;
  localparam logic [2:0] mf_wd   = 3'd4;

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [4:0]    e_dst_reg, e_rs_reg, e_rt_reg;
  logic [1:0]    e_tnew_reg;
  logic          e_link_reg;
  logic [4:0]    m_dst_reg, m_rt_reg;
  logic [1:0]    m_tnew_reg;
  logic          m_link_reg;
  // W always has tnew=0 and always forwards mf_wd, so only its destination matters.
  logic [4:0]    w_dst_reg;
  logic [CW-1:0] md_cnt_reg, md_cnt_next;

  logic [4:0] d_src  [2];
  logic [1:0] d_tuse [2];
  logic [2:0] d_sel  [2];
  logic [4:0] e_src  [2];
  logic [2:0] e_sel  [2];
  logic [1:0] op_stall;
  logic       md_stall;

  assign d_src[0]  = d_rs;
  assign d_src[1]  = d_rt;
  assign d_tuse[0] = d_rs_tuse;
  assign d_tuse[1] = d_rt_tuse;
  assign e_src[0]  = e_rs_reg;
  assign e_src[1]  = e_rt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dop
      logic       hit_e, hit_m, hit_w, stl;
      logic [1:0] tnew_y;
      logic [2:0] sel;

      assign hit_e = (d_src[gi] != 5'd0) && (e_dst_reg == d_src[gi]);
      assign hit_m = (d_src[gi] != 5'd0) && (m_dst_reg == d_src[gi]);
      assign hit_w = (d_src[gi] != 5'd0) && (w_dst_reg == d_src[gi]);

      // Youngest matching stage decides both the select and the latency compared to tuse.
      always_comb begin
        sel    = mf_rd;
        tnew_y = 2'd0;
        if (hit_e) begin
          tnew_y = e_tnew_reg;
          if (e_tnew_reg == 2'd0 && e_link_reg) sel = mf_pc4e;
        end else if (hit_m) begin
          tnew_y = m_tnew_reg;
          if (m_tnew_reg == 2'd0) sel = m_link_reg ? mf_pc4m : mf_ao;
        end else if (hit_w) begin
          sel = mf_wd;
        end
        stl = (d_tuse[gi] != 2'd3) && (tnew_y > d_tuse[gi]);
      end

      assign d_sel[gi]    = sel;
      assign op_stall[gi] = stl;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_eop
      logic       hit_m, hit_w;
      logic [2:0] sel;

      assign hit_m = (e_src[gi] != 5'd0) && (m_dst_reg == e_src[gi]);
      assign hit_w = (e_src[gi] != 5'd0) && (w_dst_reg == e_src[gi]);

      always_comb begin
        sel = mf_rd;
        if (hit_m) begin
          if (m_tnew_reg == 2'd0) sel = m_link_reg ? mf_pc4m : mf_ao;
        end else if (hit_w) begin
          sel = mf_wd;
        end
      end

      assign e_sel[gi] = sel;
    end
  endgenerate

  assign fwd_rs_d = d_sel[0];
  assign fwd_rt_d = d_sel[1];
  assign fwd_rs_e = e_sel[0];
  assign fwd_rt_e = e_sel[1];
  assign fwd_rt_m = ((m_rt_reg != 5'd0) && (w_dst_reg == m_rt_reg)) ? mf_wd : mf_rd;

  assign md_stall = (md_cnt_reg != '0) && (d_md_use || (d_md_start != 2'b00));
  assign stall    = (|op_stall) | md_stall;

  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (!stall && d_md_start == 2'b01) begin
      md_cnt_next = CW'(MULT_CYCLES);
    end else if (!stall && d_md_start == 2'b10) begin
      md_cnt_next = CW'(DIV_CYCLES);
    end else if (md_cnt_reg != '0) begin
      md_cnt_next = md_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_reg  <= 5'd0;
      e_rs_reg   <= 5'd0;
      e_rt_reg   <= 5'd0;
      e_tnew_reg <= 2'd0;
      e_link_reg <= 1'b0;
      m_dst_reg  <= 5'd0;
      m_rt_reg   <= 5'd0;
      m_tnew_reg <= 2'd0;
      m_link_reg <= 1'b0;
      w_dst_reg  <= 5'd0;
      md_cnt_reg <= '0;
    end else begin
      w_dst_reg  <= m_dst_reg;
      m_dst_reg  <= e_dst_reg;
      m_rt_reg   <= e_rt_reg;
      m_link_reg <= e_link_reg;
      m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
      if (stall) begin
        e_dst_reg  <= 5'd0;
        e_rs_reg   <= 5'd0;
        e_rt_reg   <= 5'd0;
        e_tnew_reg <= 2'd0;
        e_link_reg <= 1'b0;
      end else begin
        e_dst_reg  <= d_dst;
        e_rs_reg   <= d_rs;
        e_rt_reg   <= d_rt;
        e_tnew_reg <= d_tnew;
        e_link_reg <= d_link;
      end
      md_cnt_reg <= md_cnt_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg, md_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg    <= 32'd0;
      md_stall_cnt_reg <= 32'd0;
    end else begin
      if (stall)    stall_cnt_reg    <= stall_cnt_reg + 32'd1;
      if (md_stall) md_stall_cnt_reg <= md_stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt    = stall_cnt_reg;
  assign md_stall_cnt = md_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios, then random instruction streams
// compared against an age-based model of the instructions in flight.
module tb_hazard_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [1:0]  d_rs_tuse, d_rt_tuse, d_tnew, d_md_start;
  logic        d_link, d_md_use;
  logic        stall;
  logic [2:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_link(d_link),
    .d_md_start(d_md_start), .d_md_use(d_md_use),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // One record per issue slot; index = age (0 = in E, 1 = in M, 2 = in W).
  typedef struct {
    logic [4:0] dst;
    int         tnew;
    bit         link;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;

  rec_t        hist [3];
  int          md_left = 0;
  logic [31:0] m_stall_cnt = 0, m_md_cnt = 0;
  bit          e_stall, e_md_stall;
  logic [2:0]  e_rs_d, e_rt_d, e_rs_e, e_rt_e, e_rt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int tnow(input int age, input int orig);
    if (age == 0) return orig;
    if (age == 1) return (orig > 0) ? orig - 1 : 0;
    return 0;
  endfunction

  task automatic model_dsel(input logic [4:0] r, input int tuse,
                            output logic [2:0] sel, output bit stl);
    sel = 3'd0;
    stl = 1'b0;
    if (r == 5'd0) return;
    for (int a = 0; a < 3; a++) begin
      if (hist[a].dst == r) begin
        int tn;
        tn  = tnow(a, hist[a].tnew);
        stl = (tuse != 3) && (tn > tuse);
        if (a == 0)      sel = (tn == 0 && hist[a].link) ? 3'd1 : 3'd0;
        else if (a == 1) sel = (tn == 0) ? (hist[a].link ? 3'd3 : 3'd2) : 3'd0;
        else             sel = 3'd4;
        return;
      end
    end
  endtask

  task automatic model_esel(input logic [4:0] r, output logic [2:0] sel);
    sel = 3'd0;
    if (r == 5'd0) return;
    if (hist[1].dst == r) begin
      sel = (tnow(1, hist[1].tnew) == 0) ? (hist[1].link ? 3'd3 : 3'd2) : 3'd0;
    end else if (hist[2].dst == r) begin
      sel = 3'd4;
    end
  endtask

  task automatic set_d(input int rs, input int rt, input int rsu, input int rtu, input int dst,
                       input int tn, input int lk, input int mds, input int mdu);
    d_rs = 5'(rs);       d_rt = 5'(rt);
    d_rs_tuse = 2'(rsu); d_rt_tuse = 2'(rtu);
    d_dst = 5'(dst);     d_tnew = 2'(tn);  d_link = 1'(lk);
    d_md_start = 2'(mds); d_md_use = 1'(mdu);
  endtask

  task automatic nop();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic eval();
    bit s_rs, s_rt;
    @(negedge clk);
    model_dsel(d_rs, int'(d_rs_tuse), e_rs_d, s_rs);
    model_dsel(d_rt, int'(d_rt_tuse), e_rt_d, s_rt);
    e_md_stall = (md_left > 0) && (d_md_use || d_md_start != 2'b00);
    e_stall    = s_rs || s_rt || e_md_stall;
    model_esel(hist[0].rs, e_rs_e);
    model_esel(hist[0].rt, e_rt_e);
    e_rt_m = (hist[1].rt != 5'd0 && hist[2].dst == hist[1].rt) ? 3'd4 : 3'd0;
    check("stall", 32'(stall), 32'(e_stall));
    check("fwd_rs_d", 32'(fwd_rs_d), 32'(e_rs_d));
    check("fwd_rt_d", 32'(fwd_rt_d), 32'(e_rt_d));
    check("fwd_rs_e", 32'(fwd_rs_e), 32'(e_rs_e));
    check("fwd_rt_e", 32'(fwd_rt_e), 32'(e_rt_e));
    check("fwd_rt_m", 32'(fwd_rt_m), 32'(e_rt_m));
`ifdef HAZARD_STATS_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("md_stall_cnt", md_stall_cnt, m_md_cnt);
`endif
    $display("cyc=%0d rst=%0d rs=%0d rt=%0d dst=%0d md=%0d stall=%0d fwd=%0d/%0d/%0d/%0d/%0d",
             cyc, reset, d_rs, d_rt, d_dst, d_md_start, stall,
             fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m);
  endtask

  task automatic adv();
    rec_t bub, nxt;
    bub = '{dst: 5'd0, tnew: 0, link: 1'b0, rs: 5'd0, rt: 5'd0};
    @(posedge clk);
    if (reset) begin
      for (int a = 0; a < 3; a++) hist[a] = bub;
      md_left     = 0;
      m_stall_cnt = 0;
      m_md_cnt    = 0;
    end else begin
      if (e_stall)    m_stall_cnt = m_stall_cnt + 1;
      if (e_md_stall) m_md_cnt    = m_md_cnt + 1;
      if (!e_stall && d_md_start == 2'b01)      md_left = MULT_CYCLES;
      else if (!e_stall && d_md_start == 2'b10) md_left = DIV_CYCLES;
      else if (md_left > 0)                     md_left = md_left - 1;
      nxt = '{dst: d_dst, tnew: int'(d_tnew), link: d_link, rs: d_rs, rt: d_rt};
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e_stall ? bub : nxt;
    end
    #1;
    cyc++;
  endtask

  task automatic flush(input int n);
    repeat (n) begin nop(); eval(); adv(); end
  endtask

  initial begin
    int n;
    bit held;
    for (int a = 0; a < 3; a++) hist[a] = '{dst: 5'd0, tnew: 0, link: 1'b0, rs: 5'd0, rt: 5'd0};
    e_stall = 0; e_md_stall = 0;
    reset = 1'b1;
    nop();
    adv(); adv();
    reset = 1'b0;

    // Reset state
    eval();
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
    adv();

    // addu $3 then beq $3,$3
    set_d(1, 2, 1, 1, 3, 1, 0, 0, 0); eval(); adv();
    set_d(3, 3, 0, 0, 0, 1, 0, 0, 0); eval();
    check("alu_beq_stall", 32'(stall), 1); adv();
    eval();
    check("alu_beq_go", 32'(stall), 0);
    check("alu_beq_rs_d", 32'(fwd_rs_d), 2);
    check("alu_beq_rt_d", 32'(fwd_rt_d), 2);
    adv();
    flush(3);

    // lw $5 then addu $6,$5,$1
    set_d(1, 0, 1, 3, 5, 2, 0, 0, 0); eval(); adv();
    set_d(5, 1, 1, 1, 6, 1, 0, 0, 0); eval();
    check("lu_stall", 32'(stall), 1); adv();
    eval();
    check("lu_go", 32'(stall), 0);
    check("lu_rs_e_bubble", 32'(fwd_rs_e), 0);
    adv();
    nop(); eval();
    check("lu_rs_e_wd", 32'(fwd_rs_e), 4);
    adv();
    flush(3);

    // jal then jr $31
    set_d(0, 0, 3, 3, 31, 0, 1, 0, 0); eval(); adv();
    set_d(31, 0, 0, 3, 0, 1, 0, 0, 0); eval();
    check("jal_jr_stall", 32'(stall), 0);
    check("jal_jr_rs_d", 32'(fwd_rs_d), 1);
    adv();
    flush(3);

    // writes to $0 never forward or stall
    set_d(1, 2, 1, 1, 0, 1, 0, 0, 0); eval(); adv();
    set_d(0, 0, 0, 0, 0, 1, 0, 0, 0); eval();
    check("r0_stall", 32'(stall), 0);
    check("r0_fwd", 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
    adv();
    flush(3);

    // mult then mflo
    set_d(1, 2, 1, 1, 0, 1, 0, 1, 1); eval(); adv();
    set_d(0, 0, 3, 3, 4, 1, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      eval();
      if (!stall) break;
      n++;
      adv();
    end
    check("mult_stall_len", 32'(n), 32'(MULT_CYCLES));
    adv();
    flush(3);

    // div then mult
    set_d(1, 2, 1, 1, 0, 1, 0, 2, 1); eval(); adv();
    set_d(1, 2, 1, 1, 0, 1, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      eval();
      if (!stall) break;
      n++;
      adv();
    end
    check("div_stall_len", 32'(n), 32'(DIV_CYCLES));
    adv();
    flush(MULT_CYCLES + 1);

    // reset during a load-use stall with the md unit busy
    set_d(0, 0, 3, 3, 0, 1, 0, 1, 1); eval(); adv();
    set_d(1, 0, 1, 3, 7, 2, 0, 0, 0); eval(); adv();
    set_d(7, 1, 1, 1, 8, 1, 0, 0, 0); eval();
    check("rst_mid_pre_stall", 32'(stall), 1);
    reset = 1'b1; adv(); reset = 1'b0;
    set_d(7, 1, 1, 1, 8, 1, 0, 0, 1); eval();
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_fwd", 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
`ifdef HAZARD_STATS_EN
    check("rst_mid_stall_cnt", stall_cnt, 0);
    check("rst_mid_md_cnt", md_stall_cnt, 0);
`endif
    adv();
    flush(3);

    // random instruction stream; a stalled D instruction is re-presented until it issues
    held = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        int r_rs, r_rt, r_dst;
        r_rs  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
        r_rt  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
        r_dst = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
        set_d(r_rs, r_rt, $urandom_range(0, 3), $urandom_range(0, 3), r_dst,
              $urandom_range(0, 2), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
              ($urandom_range(0, 5) == 0) ? 1 : 0);
      end
      reset = ($urandom_range(0, 63) == 0);
      eval();
      adv();
      held = e_stall && !reset;
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
